ctrl_inputs: RTL and testbench
==============================

Name: ctrl_inputs

Overview:
- Front-end conditioner that produces the level controls `start` and `lfsr_load` consumed by the game control state machine.
- Takes raw pushbutton/switch inputs from the board pins.
- Per channel: two-flop synchronisation, then a debounce state machine, then edge-pulse generation.
- Guarantees downstream control logic sees glitch-free, clock-aligned levels and single-cycle edge pulses.

Parameters:
- DB_CYCLES, 500000, consecutive stable cycles required before an output level changes (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; requires 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start_btn  input  1  raw asynchronous start pushbutton, 1 = pressed
- load_sw  input  1  raw asynchronous LFSR-load switch, 1 = load
- start  output  1  debounced start level
- lfsr_load  output  1  debounced load level
- start_pulse  output  1  one-cycle pulse on each 0->1 of `start`
- load_rise  output  1  one-cycle pulse on each 0->1 of `lfsr_load`
- load_fall  output  1  one-cycle pulse on each 1->0 of `lfsr_load`

Behaviour:
- **Reset** (reset=0, async): all sync flops = 0, both channel FSMs = LOW, counters = 0. All outputs are 0 during reset and on the first edge after release.
- **Synchroniser:** two flops per input, s1 <= raw, s2 <= s1. Only s2 is used downstream.
- **Channel FSM**, identical and independent for start and load, states LOW, PEND_HI, HIGH, PEND_LO. The output level is 1 in HIGH and PEND_LO, 0 otherwise.
  - LOW: s2=1 -> PEND_HI, cnt<=0; else stay.
  - PEND_HI:
    - s2=0 -> LOW, cnt<=0 (bounce rejected).
    - s2=1 and cnt==DB_CYCLES-1 -> HIGH, cnt<=0.
    - Otherwise cnt<=cnt+1.
  - HIGH: s2=0 -> PEND_LO, cnt<=0; else stay.
  - PEND_LO: mirror of PEND_HI with polarities swapped.
  - Illegal encoding -> LOW, cnt<=0.
- **Latency:**
  - Raw change sampled at edge k appears on s2 after edge k+1.
  - The FSM enters PEND at edge k+2.
  - The output changes at edge k+2+DB_CYCLES, provided the input is held stable throughout.
  - Any glitch shorter than DB_CYCLES cycles (as seen on s2) produces no output change.
- **Counter:** counts only while in PEND; saturation never reached because it clears on commit.
- **Pulses:** registered compare of the current output level against its value one cycle earlier.
  - Each pulse is high for exactly the one cycle following the level change.
  - No pulse on reset release.
- **Simultaneous events:** the channels are fully independent. `start` and `lfsr_load` may change on the same cycle, and both pulses may assert together.
- **Reset mid-debounce:** the pending change is discarded, the output returns to 0, and the input must re-qualify for the full DB_CYCLES after release.
- **Raw input held 1 through reset release:** the output rises DB_CYCLES+2 cycles after release, with a start_pulse/load_rise.
- **Exclusivity:** the block does not enforce any mutual exclusion between start and load; sequencing is the controller's job.

Test Plan (DB_CYCLES=4):
1. **Reset:** hold reset=0 with start_btn=1, release -> all outputs 0 through release. `start` rises exactly 6 cycles after release, with a 1-cycle start_pulse.
2. **Clean press:** start_btn 0->1 held 20 cycles -> `start`=1 at edge k+6, start_pulse high one cycle only. Release -> `start`=0 six cycles later, no start_pulse.
3. **Bounce:** start_btn toggles 1,0,1,0 every 2 cycles, then settles 1 -> `start` stays 0 during toggling, then rises 6 cycles after the final settle, with exactly one pulse.
4. **Load cycle:** load_sw 0->1, hold 10 cycles, then 1->0 -> one load_rise and one load_fall; `lfsr_load` high for exactly 10 cycles.
5. **Simultaneous:** start_btn and load_sw rise on the same cycle -> `start` and `lfsr_load` rise together; start_pulse and load_rise coincide.
6. **Mid-debounce reset:** load_sw=1 for 3 cycles, pulse reset=0 for 1 cycle while held -> `lfsr_load` stays 0, rises 6 cycles after release, no load_fall.

Source files
------------

// File: rtl/ctrl_inputs.sv
// -----------------------------------------------------------------------------
// ctrl_inputs
//
// Conditions the raw board inputs that drive the game controller. Each of the
// two channels (start pushbutton, LFSR-load switch) goes through a two-flop
// synchroniser, a debounce state machine that only commits a level change
// after DB_CYCLES consecutive stable samples, and an edge detector that emits
// single-cycle pulses on committed level changes.
//
// Parameters
//   DB_CYCLES  stable cycles needed before a level change commits (>= 2)
//   CNT_W      debounce counter width, 2**CNT_W must exceed DB_CYCLES
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   start_btn    raw start pushbutton, 1 = pressed
//   load_sw      raw LFSR-load switch, 1 = load
//   start        debounced start level
//   lfsr_load    debounced load level
//   start_pulse  one-cycle pulse when start goes 0->1
//   load_rise    one-cycle pulse when lfsr_load goes 0->1
//   load_fall    one-cycle pulse when lfsr_load goes 1->0
// -----------------------------------------------------------------------------
module ctrl_inputs #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic start_btn,
    input  logic load_sw,
    output logic start,
    output logic lfsr_load,
    output logic start_pulse,
    output logic load_rise,
    output logic load_fall
);

    // Per-channel debounce states. PEND_* hold the old output level while the
    // new input value qualifies, so the level is 1 exactly in HIGH and PEND_LO.
    typedef enum logic [1:0] {
        LOW     = 2'b00,
        PEND_HI = 2'b01,
        HIGH    = 2'b11,
        PEND_LO = 2'b10
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Channel 0 = start, channel 1 = load.
    logic [1:0] raw;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;

    assign raw = {load_sw, start_btn};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; s2 therefore lags s1 by a
    // full cycle instead of collapsing into a single stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        db_state_t        state;
        db_state_t        state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             level_q;
        logic             level_next;
        logic             rise_q;
        logic             fall_q;

        // NOTE: every variable written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                LOW: begin
                    if (s2[ch]) begin
                        state_next = PEND_HI;
                        cnt_next   = '0;
                    end
                end
                PEND_HI: begin
                    if (!s2[ch]) begin
                        state_next = LOW;      // bounce rejected
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = HIGH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s2[ch]) begin
                        state_next = PEND_LO;
                        cnt_next   = '0;
                    end
                end
                PEND_LO: begin
                    if (s2[ch]) begin
                        state_next = HIGH;     // bounce rejected
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = LOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = LOW;
                    cnt_next   = '0;
                end
            endcase
            level_next = (state_next == HIGH) || (state_next == PEND_LO);
        end

        // The level and the pulses are registered from the next-state decode,
        // so outputs come straight from flops and each pulse lines up with the
        // first cycle of the new level.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= LOW;
                cnt     <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state   <= state_next;
                cnt     <= cnt_next;
                level_q <= level_next;
                rise_q  <= level_next & ~level_q;
                fall_q  <= ~level_next & level_q;
            end
        end

        assign level[ch] = level_q;
        assign rise[ch]  = rise_q;
        assign fall[ch]  = fall_q;
    end

    assign start       = level[0];
    assign lfsr_load   = level[1];
    assign start_pulse = rise[0];
    assign load_rise   = rise[1];
    assign load_fall   = fall[1];

endmodule

// File: tb/tb_ctrl_inputs.sv
// -----------------------------------------------------------------------------
// tb_ctrl_inputs
//
// Bench for ctrl_inputs with DB_CYCLES=4. A behavioural model tracks, per
// channel, how many consecutive synchronised samples have disagreed with the
// current output level; a level flips once that run reaches DB_CYCLES+1
// samples (one sample to leave the steady state, DB_CYCLES more to qualify).
// The expected outputs for every edge go into a queue and are popped and
// compared one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_ctrl_inputs;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;
    logic start_btn;
    logic load_sw;
    logic start;
    logic lfsr_load;
    logic start_pulse;
    logic load_rise;
    logic load_fall;

    ctrl_inputs #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .load_sw     (load_sw),
        .start       (start),
        .lfsr_load   (lfsr_load),
        .start_pulse (start_pulse),
        .load_rise   (load_rise),
        .load_fall   (load_fall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic start;
        logic lfsr_load;
        logic start_pulse;
        logic load_rise;
        logic load_fall;
    } exp_t;

    exp_t expq[$];

    int errors = 0;
    int checks = 0;
    string cur_test = "init";

    // model state
    logic [1:0] m_s1 = '0;
    logic [1:0] m_s2 = '0;
    logic [1:0] m_lvl = '0;
    int         m_run [2] = '{0, 0};

    // per-test observation counters
    int n_sp, n_lr, n_lf, n_load_hi, n_both;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s:%s got=%0d expected=%0d at %0t", cur_test, tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic sb, input logic ls, input logic rs);
        exp_t       e;
        logic [1:0] new_lvl;
        e = '0;
        if (!rs) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            m_run = '{0, 0};
        end else begin
            new_lvl = m_lvl;
            for (int ch = 0; ch < 2; ch++) begin
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DB + 1) begin
                        new_lvl[ch] = ~m_lvl[ch];
                        m_run[ch]   = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            e.start       = new_lvl[0];
            e.lfsr_load   = new_lvl[1];
            e.start_pulse = new_lvl[0] & ~m_lvl[0];
            e.load_rise   = new_lvl[1] & ~m_lvl[1];
            e.load_fall   = ~new_lvl[1] & m_lvl[1];
            m_lvl = new_lvl;
            m_s2  = m_s1;
            m_s1  = {ls, sb};
        end
        expq.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (expq.size() == 0) begin
            check("queue_empty", 1, 0);
            return;
        end
        e = expq.pop_front();
        check("start",       int'(start),       int'(e.start));
        check("lfsr_load",   int'(lfsr_load),   int'(e.lfsr_load));
        check("start_pulse", int'(start_pulse), int'(e.start_pulse));
        check("load_rise",   int'(load_rise),   int'(e.load_rise));
        check("load_fall",   int'(load_fall),   int'(e.load_fall));
        n_sp      += int'(start_pulse);
        n_lr      += int'(load_rise);
        n_lf      += int'(load_fall);
        n_load_hi += int'(lfsr_load);
        n_both    += int'(start_pulse & load_rise);
    endtask

    // One clock cycle: drive on the falling edge, model the rising edge,
    // compare just after it.
    task automatic step(input logic sb, input logic ls, input logic rs);
        @(negedge clk);
        start_btn = sb;
        load_sw   = ls;
        reset     = rs;
        @(posedge clk);
        model_edge(sb, ls, rs);
        #1;
        compare_outputs();
    endtask

    task automatic hold(input logic sb, input logic ls, input int n);
        for (int i = 0; i < n; i++) step(sb, ls, 1'b1);
    endtask

    task automatic new_test(input string name);
        cur_test  = name;
        n_sp      = 0;
        n_lr      = 0;
        n_lf      = 0;
        n_load_hi = 0;
        n_both    = 0;
    endtask

    initial begin
        reset     = 1'b0;
        start_btn = 1'b0;
        load_sw   = 1'b0;

        // 1: reset with start held, release, start qualifies afterwards
        new_test("reset");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("in_reset_start", int'(start), 0);
        hold(1'b1, 1'b0, 10);
        check("pulses", n_sp, 1);
        hold(1'b0, 1'b0, 8);

        // 2: clean press and release
        new_test("press");
        hold(1'b1, 1'b0, 20);
        check("pulses_on_press", n_sp, 1);
        hold(1'b0, 1'b0, 10);
        check("pulses_total", n_sp, 1);
        check("start_released", int'(start), 0);

        // 3: bounce every 2 cycles, then settle high
        new_test("bounce");
        for (int r = 0; r < 2; r++) begin
            hold(1'b1, 1'b0, 2);
            hold(1'b0, 1'b0, 2);
        end
        check("start_during_bounce", int'(start), 0);
        hold(1'b1, 1'b0, 12);
        check("pulses", n_sp, 1);
        hold(1'b0, 1'b0, 10);

        // 4: load held 10 cycles
        new_test("load");
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 14);
        check("rise_count", n_lr, 1);
        check("fall_count", n_lf, 1);
        check("high_cycles", n_load_hi, 10);

        // 5: both channels rise together
        new_test("simul");
        hold(1'b1, 1'b1, 12);
        check("coincident_pulses", n_both, 1);
        hold(1'b0, 1'b0, 10);

        // 6: reset pulse while load is qualifying
        new_test("mid_reset");
        hold(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 12);
        check("rise_count", n_lr, 1);
        check("fall_count", n_lf, 0);
        hold(1'b0, 1'b0, 10);

        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
